uart_word_sender: RTL and testbench
===================================

// Module: uart_word_sender
// PURPOSE
//  Upstream feeder for uart_send: buffers 32-bit words (e.g. DRAM read-back data) in a small FIFO,
//  splits each into 4 bytes MSB-first and drives uart_send's uart_en/uart_din with paced pulses.
//  uart_send has no busy output, so pacing is by a fixed byte period derived from CLK_FREQ/UART_BPS.
// PARAMETERS
//  CLK_FREQ    50000000  clk frequency in Hz (same value given to uart_send)
//  UART_BPS    115200    baud rate (same value given to uart_send)
//  FIFO_DEPTH  16        word FIFO depth; power of 2, >=2
//  EN_HOLD     8         clk cycles uart_en stays high per byte (>=4; uart_send samples on clk/2)
//  localparam BYTE_CYCLES = 2*(CLK_FREQ/UART_BPS)*11   clk cycles per byte slot (10 bits + 1 bit margin)
// PORTS
//  clk        in   1   system clock
//  sys_rst_n  in   1   asynchronous active-low reset
//  wr_en      in   1   push wr_data into FIFO this cycle
//  wr_data    in   32  word to transmit
//  full       out  1   FIFO full (registered); writes while full are dropped
//  empty      out  1   FIFO empty (registered)
//  overflow   out  1   sticky: set on any write while full; cleared only by reset
//  busy       out  1   high whenever state != IDLE
//  uart_en    out  1   to uart_send.uart_en; high EN_HOLD cycles at start of each byte slot
//  uart_din   out  8   to uart_send.uart_din; registered, stable for whole byte slot
// BEHAVIOUR
//  Reset (async): FIFO emptied, state IDLE, full=0, empty=1, overflow=0, busy=0, uart_en=0,
//   uart_din=8'h00, counters 0. Reset mid-byte drops uart_en immediately; partial word is lost.
//  FIFO: write accepted iff wr_en && !full (full as registered at that edge); pop and push in the same
//   cycle allowed; count updated accordingly. Pop occurs only in LOAD. Read data registered.
//  FSM states IDLE, LOAD, SEND:
//   IDLE: if !empty -> LOAD.
//   LOAD (1 cycle): pop head word into word_reg, byte_idx=0 -> SEND; on same edge uart_din<=word[31:24],
//    uart_en<=1, slot_cnt<=0.
//   SEND: slot_cnt increments each cycle; uart_en=1 while slot_cnt<EN_HOLD, else 0.
//    At slot_cnt==BYTE_CYCLES-1: if byte_idx<3: byte_idx++, uart_din<=next byte (31:24,23:16,15:8,7:0),
//    slot_cnt<=0, uart_en<=1, stay SEND; else if !empty -> LOAD; else -> IDLE.
//  Latency: write into empty FIFO at edge N -> empty=0 at N+1 -> LOAD at N+2 -> uart_en high from N+3.
//  Back-to-back words: 4*BYTE_CYCLES+1 cycles per word; uart_en low >= BYTE_CYCLES-EN_HOLD between bytes.
//  slot_cnt width = clog2(BYTE_CYCLES)+1; byte_idx 2 bits; FIFO pointers wrap modulo FIFO_DEPTH,
//   full/empty distinguished by an extra pointer bit.
//  wr_en while empty and state IDLE: word is eligible for LOAD next cycle, no bypass path.
// TESTING (sim with CLK_FREQ=1000000, UART_BPS=100000 -> BPS_CNT=10, BYTE_CYCLES=220, EN_HOLD=8)
//  1 Reset: hold sys_rst_n=0 -> uart_en=0, uart_din=00, empty=1, full=0, busy=0, overflow=0.
//  2 Single word 32'hA55A_0F81 at edge N -> uart_en rises at N+3, pulses at N+3,+223,+443,+663 each
//    8 cycles wide; uart_send on uart_txd decodes bytes A5,5A,0F,81 in order; busy falls at N+883.
//  3 Push 16 words back-to-back -> full=1 after 16th (minus any popped); 17th write while full ->
//    dropped, overflow=1 and stays 1; all accepted words transmitted in order, none duplicated.
//  4 Push words during transmission of word 0 (FIFO non-empty at last slot end) -> LOAD follows
//    immediately: next uart_en rise exactly 221 cycles after previous byte's rise.
//  5 Simultaneous push and pop when FIFO holds 1 word -> count unchanged, empty stays 0, pointers wrap
//    correctly after 40 words cycled through.
//  6 Assert sys_rst_n=0 mid-SEND (slot_cnt=3, uart_en=1) -> uart_en=0 same instant, FIFO empty,
//    after release a new word transmits normally starting 3 cycles after its write.

Source files
------------

// File: rtl/uart_word_sender_if.sv
// Word-push and UART-drive signals of uart_word_sender, grouped so benches and
// checkers bind to one bundle.
interface uart_word_sender_if;
    // wr_en is a single-cycle push with no ready: the word is taken on that edge
    // iff full was low, otherwise it is dropped and overflow latches.
    // uart_en/uart_din are a timed pulse, not a handshake; the receiver has no back-pressure.
    logic        wr_en;
    logic [31:0] wr_data;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        busy;
    logic        uart_en;
    logic [7:0]  uart_din;
    logic [1:0]  state_dbg;  // 0 IDLE, 1 LOAD, 2 SEND

    modport master (
        output wr_en, wr_data,
        input  full, empty, overflow, busy, uart_en, uart_din, state_dbg
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, overflow, busy, uart_en, uart_din, state_dbg
    );
endinterface

// File: rtl/uart_word_sender.sv
// Buffers 32-bit words in a FIFO and feeds them MSB-first, one byte per fixed
// time slot, to a uart_send that has no busy indication.
module uart_word_sender #(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int EN_HOLD    = 8
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    uart_word_sender_if.slave bus
);
    localparam int BYTE_CYCLES = 2 * (CLK_FREQ / UART_BPS) * 11;
    localparam int SLOT_W      = $clog2(BYTE_CYCLES) + 1;
    localparam int AW          = $clog2(FIFO_DEPTH);

    localparam logic [AW:0]       PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [SLOT_W-1:0] SLOT_ONE  = {{(SLOT_W-1){1'b0}}, 1'b1};
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(BYTE_CYCLES - 1);
    localparam logic [SLOT_W-1:0] EN_LAST   = SLOT_W'(EN_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              full_q, full_d, empty_q, empty_d, overflow_q;
    logic              push, pop;
    logic [31:0]       head;
    logic [31:0]       word_q, word_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        idx_q, idx_d;
    logic              en_q, en_d;
    logic [7:0]        din_q, din_d;
    logic              slot_end;

    assign push     = bus.wr_en && !full_q;
    assign head     = mem[rd_ptr_q[AW-1:0]];
    assign slot_end = (slot_q == SLOT_LAST);

    assign wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    // full tracks the post-edge pointers so a full FIFO is never overwritten;
    // empty deliberately lags one cycle, which sets the write-to-LOAD latency.
    assign full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                      (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    assign empty_d  = (wr_ptr_q == rd_ptr_q);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_q | (bus.wr_en & full_q);
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!empty_q) state_d = LOAD;
            LOAD: state_d = SEND;
            SEND: begin
                if (slot_end && idx_q == 2'd3) begin
                    state_d = empty_q ? IDLE : LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop    = 1'b0;
        word_d = word_q;
        slot_d = slot_q;
        idx_d  = idx_q;
        en_d   = 1'b0;
        din_d  = din_q;
        case (state_q)
            LOAD: begin
                pop    = 1'b1;
                word_d = head;
                idx_d  = 2'd0;
                slot_d = '0;
                en_d   = 1'b1;
                din_d  = head[31:24];
            end
            SEND: begin
                if (slot_end) begin
                    slot_d = '0;
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 2'd1;
                        en_d  = 1'b1;
                        case (idx_q)
                            2'd0:    din_d = word_q[23:16];
                            2'd1:    din_d = word_q[15:8];
                            default: din_d = word_q[7:0];
                        endcase
                    end
                end else begin
                    slot_d = slot_q + SLOT_ONE;
                    // Pulse covers slot counts 0..EN_HOLD-1.
                    en_d   = (slot_q < EN_LAST);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            word_q <= '0;
            slot_q <= '0;
            idx_q  <= '0;
            en_q   <= 1'b0;
            din_q  <= 8'h00;
        end else begin
            word_q <= word_d;
            slot_q <= slot_d;
            idx_q  <= idx_d;
            en_q   <= en_d;
            din_q  <= din_d;
        end
    end

    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.uart_en   = en_q;
    assign bus.uart_din  = din_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_uart_word_sender.sv
// Bench for uart_word_sender: random words go into a byte scoreboard, a negedge
// monitor checks every byte slot, pulse shape and FIFO flags against the model.
module tb_uart_word_sender;
    localparam int CLK_FREQ    = 1000000;
    localparam int UART_BPS    = 100000;
    localparam int FIFO_DEPTH  = 16;
    localparam int EN_HOLD     = 8;
    localparam int BYTE_CYCLES = 2 * (CLK_FREQ / UART_BPS) * 11;
    localparam int WORD_CYCLES = 4 * BYTE_CYCLES + 1;

    logic clk = 1'b0;
    logic sys_rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    logic [7:0] exp_q[$];
    int         rise_log[$];
    int         acc_cnt = 0;
    int         pop_cnt = 0;
    int         tx_bytes = 0;
    logic       exp_ovf = 1'b0;

    uart_word_sender_if bus();

    uart_word_sender #(
        .CLK_FREQ  (CLK_FREQ),
        .UART_BPS  (UART_BPS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .EN_HOLD   (EN_HOLD)
    ) dut (
        .clk      (clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // A word is accepted iff the FIFO (words accepted minus words started) was
    // below capacity before this edge; accepted words become 4 MSB-first bytes.
    always @(posedge clk) begin
        if (!sys_rst_n) begin
            exp_q.delete();
            acc_cnt = 0;
            exp_ovf = 1'b0;
        end else if (bus.wr_en) begin
            if (acc_cnt - pop_cnt >= FIFO_DEPTH) begin
                exp_ovf = 1'b1;
            end else begin
                for (int b = 3; b >= 0; b--) exp_q.push_back(bus.wr_data[8*b +: 8]);
                acc_cnt++;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic       en_prev = 1'b0;
    int         hi_len = 0;
    int         byte_idx = 0;
    int         last_rise = 0;
    int         prev_count = 0;
    logic [7:0] cur_byte = 8'h00;

    always @(negedge clk) begin
        if (!sys_rst_n) begin
            en_prev    = 1'b0;
            hi_len     = 0;
            byte_idx   = 0;
            pop_cnt    = 0;
            prev_count = 0;
            cur_byte   = 8'h00;
        end else begin
            int cnt_now;
            if (bus.uart_en && !en_prev) begin
                if (byte_idx == 0) pop_cnt++;
                else chk("byte_spacing", 32'(cyc - last_rise), 32'(BYTE_CYCLES));
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no byte (cycle %0d)",
                             bus.uart_din, cyc);
                end else begin
                    chk("byte_value", 32'(bus.uart_din), 32'(exp_q.pop_front()));
                end
                cur_byte  = bus.uart_din;
                last_rise = cyc;
                rise_log.push_back(cyc);
                byte_idx  = (byte_idx + 1) % 4;
                tx_bytes++;
            end else begin
                chk("din_stable", 32'(bus.uart_din), 32'(cur_byte));
            end
            if (bus.uart_en) begin
                hi_len++;
            end else if (en_prev) begin
                chk("en_width", 32'(hi_len), 32'(EN_HOLD));
                hi_len = 0;
            end
            en_prev = bus.uart_en;
            cnt_now = acc_cnt - pop_cnt;
            chk("full", 32'(bus.full), 32'(cnt_now == FIFO_DEPTH));
            chk("empty", 32'(bus.empty), 32'(prev_count == 0));
            chk("overflow", 32'(bus.overflow), 32'(exp_ovf));
            prev_count = cnt_now;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of the edge that samples the write.
    task automatic push(input logic [31:0] d, output int edge_n);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        edge_n      = cyc + 1;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_rises(input int target, input int budget, input string name);
        int t = 0;
        while (rise_log.size() < target && t < budget) begin
            tick();
            t++;
        end
        chk(name, 32'(rise_log.size() >= target), 32'd1);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int t = 0;
        while ((exp_q.size() != 0 || bus.busy) && t < budget) begin
            tick();
            t++;
        end
        chk(name, 32'(exp_q.size() == 0 && !bus.busy), 32'd1);
    endtask

    task automatic wait_load(input int budget);
        int t = 0;
        while (bus.state_dbg != 2'd1 && t < budget) begin
            tick();
            t++;
        end
        chk("load_timeout", 32'(bus.state_dbg == 2'd1), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, n2, base, base_tx, t;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;

        // Reset values
        sys_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_uart_en", 32'(bus.uart_en), 32'd0);
        chk("rst_uart_din", 32'(bus.uart_din), 32'h00);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        sys_rst_n = 1'b1;
        repeat (2) tick();

        // Single word: slot timing and busy duration
        base = rise_log.size();
        push(32'hA55A_0F81, n);
        wait_rises(base + 4, 1000, "t2_rise_timeout");
        if (rise_log.size() >= base + 4) begin
            for (int k = 0; k < 4; k++)
                chk("t2_rise_time", 32'(rise_log[base+k] - n), 32'(3 + BYTE_CYCLES * k));
        end
        t = 0;
        while (bus.busy && t < 1000) begin
            tick();
            t++;
        end
        chk("t2_busy_fall", 32'(cyc - n), 32'(4 * BYTE_CYCLES + 3));

        // Burst of 20 into a 16-deep FIFO: overflow, then drain in order
        base_tx = tx_bytes;
        for (int i = 0; i < 20; i++) push($urandom, n);
        chk("t3_overflow_set", 32'(bus.overflow), 32'd1);
        wait_drain(20 * WORD_CYCLES, "t3_drain_timeout");
        chk("t3_tx_bytes", 32'(tx_bytes - base_tx), 32'(17 * 4));
        chk("t3_overflow_sticky", 32'(bus.overflow), 32'd1);

        // Word queued during transmission: next word follows with no gap
        base = rise_log.size();
        push($urandom, n);
        repeat ($urandom_range(10, 800)) tick();
        push($urandom, n2);
        wait_rises(base + 5, 2 * WORD_CYCLES, "t4_rise_timeout");
        if (rise_log.size() >= base + 5)
            chk("t4_word_gap", 32'(rise_log[base+4] - rise_log[base+3]), 32'(BYTE_CYCLES + 1));
        wait_drain(2 * WORD_CYCLES, "t4_drain_timeout");

        // Push on the pop edge with one word stored, 40 words through the pointers
        base_tx = tx_bytes;
        push($urandom, n);
        push($urandom, n);
        for (int i = 0; i < 38; i++) begin
            wait_load(WORD_CYCLES + 10);
            push($urandom, n);
        end
        wait_drain(3 * WORD_CYCLES, "t5_drain_timeout");
        chk("t5_tx_bytes", 32'(tx_bytes - base_tx), 32'(40 * 4));

        // Reset in the middle of a byte pulse, then a clean restart
        base = rise_log.size();
        push($urandom, n);
        push($urandom, n);
        wait_rises(base + 1, 50, "t6_rise_timeout");
        repeat (2) tick();
        chk("t6_en_before_rst", 32'(bus.uart_en), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        chk("t6_en_rst", 32'(bus.uart_en), 32'd0);
        chk("t6_empty_rst", 32'(bus.empty), 32'd1);
        chk("t6_busy_rst", 32'(bus.busy), 32'd0);
        chk("t6_din_rst", 32'(bus.uart_din), 32'h00);
        repeat (2) tick();
        sys_rst_n = 1'b1;
        tick();
        base = rise_log.size();
        push($urandom, n);
        wait_rises(base + 1, 50, "t6_restart_timeout");
        if (rise_log.size() >= base + 1)
            chk("t6_restart_latency", 32'(rise_log[base] - n), 32'd3);
        wait_drain(2 * WORD_CYCLES, "t6_drain_timeout");
        chk("leftover_bytes", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
